wave_capture_buf: RTL and testbench

//  Multi-channel triggered waveform capture buffer; successor to the single-port-pair sample RAM in front of the FFT.

---
 rtl/wave_capture_pkg.sv | 12 +
 rtl/wave_capture_sdpram.sv | 30 +++
 rtl/wave_capture_buf.sv | 158 +++++++++++++++
 tb/tb_wave_capture_buf.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wave_capture_pkg.sv
// Shared types for the triggered waveform capture buffer.
package wave_capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE, S_READ
  } state_t;

  function automatic int frame_w(input int nch, input int dw);
    return nch * dw;
  endfunction

endpackage

// File: rtl/wave_capture_sdpram.sv
// Simple dual-port RAM, registered read; rd output holds while re is low.
module wave_capture_sdpram
  import wave_capture_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // clr only zeroes the output register; stored frames survive abort
  always_ff @(posedge clk) begin
    if (clr)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/wave_capture_buf.sv
// Multi-channel triggered capture into a circular RAM, streamed out oldest first.
// Optional WAVE_CAPTURE_BUF_DECIM_EN adds a decim port (store one of every decim+1 frames).
module wave_capture_buf
  import wave_capture_pkg::*;
#(
  parameter  int NCH    = 2,
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 10,
  localparam int TSW    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int FW     = frame_w(NCH, DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [FW-1:0]     din,
  input  logic              din_vld,
`ifdef WAVE_CAPTURE_BUF_DECIM_EN
  input  logic [7:0]        decim,
`endif
  input  logic [TSW-1:0]    trig_sel,
  input  logic [DATA_W-1:0] trig_lvl,
  input  logic [ADDR_W-1:0] pre_len,
  output logic              busy,
  output logic              done,
  input  logic              rd_start,
  input  logic              rd_ready,
  output logic [FW-1:0]     rd_data,
  output logic              rd_valid,
  output logic              rd_last
);

  localparam int DEPTH = 2**ADDR_W;

  state_t state, state_nxt;

  logic [NCH-1:0][DATA_W-1:0] din_ch;
  logic [ADDR_W-1:0] wr_ptr, cnt, pre_len_q, post_rem, start_addr, rd_ptr;
  logic [ADDR_W:0]   rd_rem;
  logic [TSW-1:0]    trig_sel_q;
  logic [DATA_W-1:0] trig_lvl_q, prev, cur;
  logic              prev_ok, capturing, take, wr_en, trig, rd_issue, rd_accept;

  assign din_ch    = din;
  assign cur       = din_ch[trig_sel_q];
  assign capturing = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);

`ifdef WAVE_CAPTURE_BUF_DECIM_EN
  logic [7:0] phase;
  assign take = din_vld && (phase == 8'd0);
`else
  assign take = din_vld;
`endif

  assign wr_en     = capturing && take;
  assign trig      = (state == S_WAIT) && wr_en && prev_ok &&
                     (prev < trig_lvl_q) && (cur >= trig_lvl_q);
  assign rd_issue  = (state == S_READ) && (rd_rem != '0) && (!rd_valid || rd_ready);
  assign rd_accept = rd_valid && rd_ready;
  assign busy      = capturing || (state == S_READ);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (arm) state_nxt = (pre_len == '0) ? S_WAIT : S_PRE;
      S_PRE:  if (wr_en && cnt == pre_len_q - ADDR_W'(1)) state_nxt = S_WAIT;
      S_WAIT: if (trig) state_nxt = (&pre_len_q) ? S_DONE : S_POST;
      S_POST: if (wr_en && post_rem == ADDR_W'(1)) state_nxt = S_DONE;
      S_DONE: if (rd_start) state_nxt = S_READ;
      S_READ: if (rd_accept && rd_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      cnt        <= '0;
      pre_len_q  <= '0;
      post_rem   <= '0;
      start_addr <= '0;
      rd_ptr     <= '0;
      rd_rem     <= '0;
      trig_sel_q <= '0;
      trig_lvl_q <= '0;
      prev       <= '0;
      prev_ok    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
`ifdef WAVE_CAPTURE_BUF_DECIM_EN
      phase      <= '0;
`endif
    end else begin
      if (state == S_IDLE && arm && !abort) begin
        wr_ptr     <= '0;
        cnt        <= '0;
        pre_len_q  <= pre_len;
        trig_sel_q <= trig_sel;
        trig_lvl_q <= trig_lvl;
        prev_ok    <= 1'b0;
`ifdef WAVE_CAPTURE_BUF_DECIM_EN
        phase      <= '0;
`endif
      end
`ifdef WAVE_CAPTURE_BUF_DECIM_EN
      if (capturing && din_vld) phase <= (phase == decim) ? 8'd0 : phase + 8'd1;
`endif
      if (wr_en) begin
        wr_ptr  <= wr_ptr + ADDR_W'(1);
        prev    <= cur;
        prev_ok <= 1'b1;
      end
      if (state == S_PRE && wr_en) cnt <= cnt + ADDR_W'(1);
      // ~pre_len is DEPTH-1-pre_len in ADDR_W bits
      if (trig) begin
        start_addr <= wr_ptr - pre_len_q;
        post_rem   <= ~pre_len_q;
      end
      if (state == S_POST && wr_en) post_rem <= post_rem - ADDR_W'(1);
      if (state == S_DONE && rd_start) begin
        rd_ptr <= start_addr;
        rd_rem <= (ADDR_W+1)'(DEPTH);
      end
      if (rd_issue) begin
        rd_ptr   <= rd_ptr + ADDR_W'(1);
        rd_rem   <= rd_rem - (ADDR_W+1)'(1);
        rd_valid <= 1'b1;
        rd_last  <= (rd_rem == (ADDR_W+1)'(1));
      end else if (rd_accept) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
      if (abort) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

  wave_capture_sdpram #(.AW(ADDR_W), .DW(FW)) u_ram (
    .clk   (clk),
    .clr   (rst || abort),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_issue),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_wave_capture_buf.sv
// Scoreboard bench for wave_capture_buf: a window model over the written-frame list feeds an expected-beat queue.
module tb_wave_capture_buf;

  localparam int NCH = 2, DW = 8, AW = 4, DEPTH = 16, FW = 16, BUDGET = 300;

  logic          clk = 1'b0, rst = 1'b1, arm = 1'b0, abort = 1'b0, din_vld = 1'b0;
  logic          rd_start = 1'b0, rd_ready = 1'b0;
  logic [FW-1:0] din = '0;
  logic [0:0]    trig_sel = '0;
  logic [DW-1:0] trig_lvl = '0;
  logic [AW-1:0] pre_len = '0;
  logic          busy, done, rd_valid, rd_last;
  logic [FW-1:0] rd_data;
`ifdef WAVE_CAPTURE_BUF_DECIM_EN
  logic [7:0]    decim = '0;
`endif

  typedef struct {logic [FW-1:0] d; logic l;} beat_t;
  beat_t         exp_q[$];
  beat_t         pend_q[$];
  logic [FW-1:0] frames [BUDGET];
  int            total = 0, bad = 0, dec_v = 0, rd_mode = 0;
  bit            reading = 1'b0;

  always #5 clk = ~clk;

  wave_capture_buf #(.NCH(NCH), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .din(din), .din_vld(din_vld),
`ifdef WAVE_CAPTURE_BUF_DECIM_EN
    .decim(decim),
`endif
    .trig_sel(trig_sel), .trig_lvl(trig_lvl), .pre_len(pre_len),
    .busy(busy), .done(done), .rd_start(rd_start), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Written frames are every (dec_v+1)-th frame after arm; the capture is the DEPTH-frame
  // window of that list starting pre frames before the first qualifying crossing.
  task automatic model(input int pre, input int lvl, input int sel, output int n_exp);
    int w[$];
    int t;
    beat_t b;
    t = -1;
    n_exp = 0;
    for (int i = 0; i < BUDGET; i++) if (i % (dec_v + 1) == 0) w.push_back(i);
    for (int k = (pre > 0) ? pre : 1; k < w.size(); k++) begin
      if (int'(frames[w[k-1]][sel*DW +: DW]) < lvl && int'(frames[w[k]][sel*DW +: DW]) >= lvl) begin
        t = k;
        break;
      end
    end
    if (t >= 0 && t + DEPTH - 1 - pre < w.size()) begin
      n_exp = w[t + DEPTH - 1 - pre] + 1;
      for (int j = 0; j < DEPTH; j++) begin
        b.d = frames[w[t - pre + j]];
        b.l = (j == DEPTH - 1);
        pend_q.push_back(b);
      end
    end
  endtask

  task automatic run_capture(input int pre, input int lvl, input int sel, input int mode);
    int n_exp, n_seen, c;
    n_seen = 0;
    pend_q.delete();
    model(pre, lvl, sel, n_exp);
    trig_sel = 1'(sel);
    trig_lvl = 8'(lvl);
    pre_len  = 4'(pre);
`ifdef WAVE_CAPTURE_BUF_DECIM_EN
    decim = 8'(dec_v);
`endif
    arm = 1'b1; tick; arm = 1'b0;
    check("armed_busy", busy, 1);
    for (int i = 0; i < BUDGET && n_seen == 0; i++) begin
      din = frames[i]; din_vld = 1'b1; tick;
      if (done) n_seen = i + 1;
    end
    din_vld = 1'b0;
    check("done_at", n_seen, n_exp);
    if (n_seen == 0 || n_exp == 0) begin
      abort = 1'b1; tick; abort = 1'b0;
      return;
    end
    while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
    rd_mode = mode;
    rd_start = 1'b1; tick; rd_start = 1'b0;
    reading = 1'b1;
    c = 0;
    while ((exp_q.size() != 0 || busy) && c < 400) begin tick; c++; end
    check("beats_left", exp_q.size(), 0);
    check("busy_after_read", busy, 0);
    check("valid_after_read", rd_valid, 0);
    reading = 1'b0;
    exp_q.delete();
  endtask

  task automatic ramp(input int step);
    for (int i = 0; i < BUDGET; i++) frames[i] = {8'h00, 8'(i * step)};
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (!reading) rd_ready = 1'b0;
      else case (rd_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ~rd_ready;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    logic stall, hl;
    logic [FW-1:0] hd;
    beat_t e;
    stall = 1'b0; hl = 1'b0; hd = '0;
    forever begin
      @(negedge clk);
      if (stall) begin
        check("stall_valid", rd_valid, 1);
        check("stall_data", rd_data, hd);
        check("stall_last", rd_last, hl);
      end
      if (rd_valid && rd_ready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_data", rd_data, e.d);
          check("beat_last", rd_last, e.l);
        end
      end
      stall = rd_valid && !rd_ready;
      hd = rd_data;
      hl = rd_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick; tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_last", rd_last, 0);
    check("rst_data", rd_data, 0);
    rst = 1'b0; tick;

    ramp(8);
    run_capture(4, 8'h80, 0, 0);
    run_capture(0, 8'h80, 0, 0);
    run_capture(15, 8'h80, 0, 0);
    run_capture(4, 8'h80, 0, 1);

    for (int i = 0; i < BUDGET; i++) frames[i] = {(i < 24) ? 8'h10 : 8'hA0, 8'(i * 8)};
    run_capture(4, 8'h80, 1, 0);

    // abort partway through POST, then confirm rd_start is ignored
    ramp(8);
    trig_sel = 1'b0; trig_lvl = 8'h80; pre_len = 4'd4;
    arm = 1'b1; tick; arm = 1'b0;
    for (int i = 0; i < 20; i++) begin din = frames[i]; din_vld = 1'b1; tick; end
    check("post_busy", busy, 1);
    abort = 1'b1; tick; abort = 1'b0; din_vld = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_valid", rd_valid, 0);
    rd_start = 1'b1; tick; rd_start = 1'b0; tick;
    check("rdstart_idle_busy", busy, 0);
    check("rdstart_idle_valid", rd_valid, 0);
    run_capture(4, 8'h80, 0, 2);

    arm = 1'b1; abort = 1'b1; tick; arm = 1'b0; abort = 1'b0;
    check("arm_abort_busy", busy, 0);
    for (int i = 0; i < 40; i++) begin din = frames[i]; din_vld = 1'b1; tick; end
    din_vld = 1'b0;
    check("arm_abort_idle", busy || done, 0);

`ifdef WAVE_CAPTURE_BUF_DECIM_EN
    dec_v = 1;
    run_capture(4, 8'h80, 0, 0);
    dec_v = 0;
`endif

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < BUDGET; i++) frames[i] = 16'($urandom);
      run_capture(int'($urandom_range(0, 15)), int'($urandom_range(1, 255)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
